// File: rtl/spike_rate_decoder.sv
// ============================================================================
// spike_rate_decoder
// ----------------------------------------------------------------------------
// Turns per-channel spike trains back into multi-bit magnitudes. Spikes are
// counted per channel over a programmable window of enabled cycles. At the
// end of every window the per-channel counts are latched together with the
// most active channel, the population total, a saturation flag and a
// nonzero flag. A one-cycle frame_valid pulse marks each new set of values.
//
// Parameters
//   N_CH   number of spike channels (power of two, 2..8)
//   CNT_W  per-channel count width; counts saturate at 2^CNT_W-1
//   WIN_W  window-length field width
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset, priority over ena
//   ena          cycle enable; low freezes timer, counters and latched values
//   spike_in     one spike bit per channel, sampled on enabled cycles
//   win_len      window length minus one; loaded at reset and window end
//   sel          channel select for rate_out
//   rate_out     latched count of channel sel (combinational read)
//   winner       lowest-index channel holding the maximum latched count
//   any_spike    latched total is nonzero
//   total_out    sum of the latched counts
//   sat_out      at least one channel saturated in the latched window
//   frame_valid  one-cycle pulse in the cycle after each window ends
// ============================================================================
module spike_rate_decoder #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [N_CH-1:0]                  spike_in,
    input  logic [WIN_W-1:0]                 win_len,
    input  logic [$clog2(N_CH)-1:0]          sel,
    output logic [CNT_W-1:0]                 rate_out,
    output logic [$clog2(N_CH)-1:0]          winner,
    output logic                             any_spike,
    output logic [CNT_W+$clog2(N_CH)-1:0]    total_out,
    output logic                             sat_out,
    output logic                             frame_valid
);

    localparam int SEL_W = $clog2(N_CH);
    // Sum of N_CH saturated counts fits in CNT_W+SEL_W bits without overflow.
    localparam int TOT_W = CNT_W + SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIN_W-1:0] timer_q;
    logic [WIN_W-1:0] len_q;
    logic [CNT_W-1:0] live_q [N_CH];
    logic [CNT_W-1:0] lat_q  [N_CH];
    logic [SEL_W-1:0] winner_q;
    logic [TOT_W-1:0] total_q;
    logic             sat_q;
    logic             any_q;
    logic             frame_valid_q;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic             win_end;
    logic [CNT_W-1:0] inc    [N_CH];
    logic [CNT_W-1:0] best;
    logic [SEL_W-1:0] best_idx;
    logic [TOT_W-1:0] total_sum;
    logic             any_sat;

    // The last cycle of a window is the enabled cycle whose timer has reached
    // the length captured at the start of that window.
    assign win_end = ena && (timer_q == len_q);

    // Saturating increment of each live counter by this cycle's spike. At a
    // window end this is also the final count, so the last-cycle spike is
    // included in the latched value.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            inc[i] = live_q[i];
            if (spike_in[i] && (live_q[i] != CNT_MAX)) begin
                inc[i] = live_q[i] + CNT_W'(1);
            end
        end
    end

    // Window statistics from the final counts. Strict '>' keeps the first
    // (lowest-index) channel on ties, and leaves winner at 0 when all are 0.
    // NOTE: blocking assignments here model a running accumulation inside a
    // combinational block; every output gets its default before the loop so
    // no latch is inferred.
    always_comb begin
        best      = '0;
        best_idx  = '0;
        total_sum = '0;
        any_sat   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (inc[i] > best) begin
                best     = inc[i];
                best_idx = SEL_W'(i);
            end
            total_sum = total_sum + TOT_W'(inc[i]);
            any_sat   = any_sat | (inc[i] == CNT_MAX);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q       <= '0;
            // The first window length is taken from win_len while in reset.
            len_q         <= win_len;
            // NOTE: the counter arrays are plain flops (N_CH entries), so they
            // are cleared like any other register; a partial window must not
            // survive reset.
            for (int i = 0; i < N_CH; i++) begin
                live_q[i] <= '0;
                lat_q[i]  <= '0;
            end
            winner_q      <= '0;
            total_q       <= '0;
            sat_q         <= 1'b0;
            any_q         <= 1'b0;
            frame_valid_q <= 1'b0;
        end else if (ena) begin
            if (win_end) begin
                timer_q       <= '0;
                // A win_len change mid-window only takes effect here.
                len_q         <= win_len;
                for (int i = 0; i < N_CH; i++) begin
                    lat_q[i]  <= inc[i];
                    // The final-cycle spike is not carried forward.
                    live_q[i] <= '0;
                end
                winner_q      <= best_idx;
                total_q       <= total_sum;
                sat_q         <= any_sat;
                any_q         <= (total_sum != '0);
                frame_valid_q <= 1'b1;
            end else begin
                timer_q       <= timer_q + WIN_W'(1);
                for (int i = 0; i < N_CH; i++) begin
                    live_q[i] <= inc[i];
                end
                frame_valid_q <= 1'b0;
            end
        end else begin
            // Disabled cycles hold everything but never stretch the pulse.
            frame_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rate_out    = lat_q[sel];
    assign winner      = winner_q;
    assign any_spike   = any_q;
    assign total_out   = total_q;
    assign sat_out     = sat_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ============================================================================
// tb_spike_rate_decoder
// ----------------------------------------------------------------------------
// Directed self-checking bench for spike_rate_decoder (N_CH=8, CNT_W=8,
// WIN_W=8). Inputs change 1 ns after a rising edge and outputs are sampled
// at the same point, well away from the next active edge.
// ============================================================================
module tb_spike_rate_decoder;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 8;
    localparam int SEL_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ena;
    logic [N_CH-1:0]        spike_in;
    logic [WIN_W-1:0]       win_len;
    logic [SEL_W-1:0]       sel;
    logic [CNT_W-1:0]       rate_out;
    logic [SEL_W-1:0]       winner;
    logic                   any_spike;
    logic [CNT_W+SEL_W-1:0] total_out;
    logic                   sat_out;
    logic                   frame_valid;

    int checks   = 0;
    int failures = 0;

    spike_rate_decoder #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spike_in    (spike_in),
        .win_len     (win_len),
        .sel         (sel),
        .rate_out    (rate_out),
        .winner      (winner),
        .any_spike   (any_spike),
        .total_out   (total_out),
        .sat_out     (sat_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clocks until frame_valid is seen; a missing frame shows up as
    // a count equal to the bound, which never matches a legal window length.
    task automatic wait_frame(input string tag, input int exp_len);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 1000) begin
            tick();
            n++;
            if (frame_valid) seen = 1'b1;
        end
        check(tag, n, exp_len);
    endtask

    task automatic read_ch(input string tag, input int ch, input int exp);
        sel = SEL_W'(ch);
        #1;
        check(tag, rate_out, exp);
    endtask

    // One-clock reset that also loads win_len into the window-length register.
    task automatic do_reset(input logic [WIN_W-1:0] len);
        win_len = len;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
    endtask

    initial begin
        logic [N_CH-1:0] tie_vec [4];
        tie_vec[0] = 8'h08;
        tie_vec[1] = 8'h20;
        tie_vec[2] = 8'h20;
        tie_vec[3] = 8'h0A;

        // ---------------- Reset with spikes active ----------------
        rst      = 1'b1;
        ena      = 1'b1;
        spike_in = 8'hFF;
        win_len  = 8'd3;
        sel      = '0;
        tick();
        tick();
        check("rst_rate",  rate_out,    0);
        check("rst_win",   winner,      0);
        check("rst_any",   any_spike,   0);
        check("rst_total", total_out,   0);
        check("rst_sat",   sat_out,     0);
        check("rst_fv",    frame_valid, 0);

        // ---------------- Constant pattern ----------------
        rst      = 1'b0;
        spike_in = 8'b0000_0101;
        wait_frame("const_first_frame", 4);
        read_ch("const_ch0", 0, 4);
        read_ch("const_ch1", 1, 0);
        read_ch("const_ch2", 2, 4);
        read_ch("const_ch7", 7, 0);
        check("const_winner", winner,    0);
        check("const_total",  total_out, 8);
        check("const_sat",    sat_out,   0);
        check("const_any",    any_spike, 1);
        tick();
        check("const_fv_width", frame_valid, 0);
        wait_frame("const_second_frame", 3);
        check("const_total2", total_out, 8);

        // ---------------- Saturation ----------------
        spike_in = 8'h80;
        do_reset(8'd255);
        wait_frame("sat_frame", 256);
        read_ch("sat_ch7", 7, 255);
        read_ch("sat_ch0", 0, 0);
        check("sat_flag",   sat_out,   1);
        check("sat_winner", winner,    7);
        check("sat_total",  total_out, 255);
        wait_frame("sat_frame2", 256);
        read_ch("sat_ch7_again", 7, 255);
        check("sat_total2", total_out, 255);

        // ---------------- Enable gating ----------------
        spike_in = 8'hFF;
        do_reset(8'd3);
        for (int t = 1; t <= 16; t++) begin
            ena = t[0];
            tick();
            check($sformatf("gate_fv_t%0d", t), frame_valid,
                  (t == 7 || t == 15) ? 1 : 0);
            if (t == 7) begin
                for (int c = 0; c < N_CH; c++) begin
                    read_ch($sformatf("gate_ch%0d", c), c, 4);
                end
                check("gate_total", total_out, 32);
            end
        end
        ena = 1'b1;

        // ---------------- Tie and last-cycle spike ----------------
        do_reset(8'd3);
        for (int c = 0; c < 4; c++) begin
            spike_in = tie_vec[c];
            tick();
        end
        spike_in = '0;
        check("tie_fv",     frame_valid, 1);
        read_ch("tie_ch3", 3, 2);
        read_ch("tie_ch5", 5, 2);
        read_ch("tie_ch1", 1, 1);
        check("tie_winner", winner,    3);
        check("tie_total",  total_out, 5);
        // Silent window: all-zero counts.
        wait_frame("zero_frame", 4);
        check("zero_winner", winner,    0);
        check("zero_any",    any_spike, 0);
        check("zero_total",  total_out, 0);

        // ---------------- Mid-window win_len change ----------------
        spike_in = 8'hFF;
        do_reset(8'd3);
        tick();                     // window cycle 0
        win_len = 8'd1;             // changed during cycle 1
        wait_frame("mid_len_cur", 3);
        wait_frame("mid_len_next", 2);
        check("mid_total_short", total_out, 16);
        wait_frame("mid_len_next2", 2);

        // ---------------- Reset mid-window ----------------
        win_len = 8'd3;
        wait_frame("mid_reload", 2);
        wait_frame("mid_long", 4);
        check("pre_rst_total", total_out, 32);
        tick();                     // cycle 0
        tick();                     // cycle 1
        rst = 1'b1;                 // asserted in cycle 2
        tick();
        rst = 1'b0;
        check("mrst_fv",    frame_valid, 0);
        check("mrst_total", total_out,   0);
        check("mrst_any",   any_spike,   0);
        read_ch("mrst_ch0", 0, 0);
        wait_frame("mrst_frame", 4);
        check("mrst_total2", total_out, 32);

        // ---------------- One-cycle windows ----------------
        do_reset(8'd0);
        spike_in = 8'h01;
        tick();
        check("w0_fv_a", frame_valid, 1);
        read_ch("w0_ch0_a", 0, 1);
        spike_in = 8'h00;
        tick();
        check("w0_fv_b", frame_valid, 1);
        read_ch("w0_ch0_b", 0, 0);
        spike_in = 8'h01;
        ena      = 1'b0;
        tick();
        check("w0_fv_off", frame_valid, 0);
        read_ch("w0_ch0_hold", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
